// File: rtl/nes_host_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nes_host_loader_if                                                 |
// | Host command bus plus NES core memory/CPU control bundle.          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface nes_host_loader_if;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [15:0] writedata;
  logic [15:0] address;
  logic [7:0]  readdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_in;
  logic        mem_write;
  logic        cpu_reset;
  logic        cpu_ready;
  logic [15:0] cpu_start_addr;
  logic        busy;

  modport master (
    output chipselect, write, read, writedata, address,
    input  readdata, mem_addr, mem_in, mem_write, cpu_reset, cpu_ready,
           cpu_start_addr, busy
  );

  modport slave (
    input  chipselect, write, read, writedata, address,
    output readdata, mem_addr, mem_in, mem_write, cpu_reset, cpu_ready,
           cpu_start_addr, busy
  );
endinterface
`default_nettype wire

// File: rtl/nes_host_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nes_host_loader                                                    |
// | Queues host commands and drains them into NES memory/CPU controls. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module nes_host_loader #(
  parameter int FIFO_DEPTH   = 8,
  parameter int RESET_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  nes_host_loader_if.slave bus
);
  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = $clog2(RESET_CYCLES + 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_HOLD = 2'd1;
  localparam logic [1:0] c_RUN  = 2'd2;

  localparam logic [7:0] c_OP_RESET = 8'h00;
  localparam logic [7:0] c_OP_START = 8'h01;
  localparam logic [7:0] c_OP_WRITE = 8'h02;

  localparam logic [c_CNT_W-1:0] c_HOLD_LOAD = c_CNT_W'(RESET_CYCLES - 1);

  logic [31:0]        r_fifo [FIFO_DEPTH];
  logic [c_PTR_W:0]   r_wr_ptr;
  logic [c_PTR_W:0]   r_rd_ptr;
  logic [1:0]         r_state;
  logic [c_CNT_W-1:0] r_hold_cnt;
  logic               r_overflow;
  logic [7:0]         r_readdata;
  logic [15:0]        r_mem_addr;
  logic [7:0]         r_mem_in;
  logic               r_mem_write;
  logic               r_cpu_reset;
  logic               r_cpu_ready;
  logic [15:0]        r_cpu_start_addr;

  logic        w_empty;
  logic        w_full;
  logic        w_push_req;
  logic        w_push;
  logic        w_pop;
  logic        w_status_rd;
  logic [31:0] w_head;
  logic [7:0]  w_op;
  logic [7:0]  w_data;
  logic [15:0] w_addr;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                       (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
  assign w_push_req  = bus.chipselect & bus.write;
  assign w_push      = w_push_req & ~w_full;
  assign w_pop       = ~w_empty & (r_state != c_HOLD);
  assign w_status_rd = bus.chipselect & bus.read;
  assign w_head      = r_fifo[r_rd_ptr[c_PTR_W-1:0]];
  assign w_op        = w_head[31:24];
  assign w_data      = w_head[23:16];
  assign w_addr      = w_head[15:0];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr[c_PTR_W-1:0]] <= {bus.writedata, bus.address};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_state          <= c_IDLE;
      r_hold_cnt       <= '0;
      r_overflow       <= 1'b0;
      r_readdata       <= 8'h00;
      r_mem_addr       <= 16'h0000;
      r_mem_in         <= 8'h00;
      r_mem_write      <= 1'b0;
      r_cpu_reset      <= 1'b1;
      r_cpu_ready      <= 1'b0;
      r_cpu_start_addr <= 16'h0000;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

      // A dropped write in the same cycle as a status read keeps overflow set.
      if (w_push_req && w_full) begin
        r_overflow <= 1'b1;
      end else if (w_status_rd) begin
        r_overflow <= 1'b0;
      end

      if (w_status_rd) begin
        r_readdata <= {3'b000, r_state == c_HOLD, r_state == c_RUN,
                       r_overflow, w_full, w_empty};
      end

      r_mem_write <= 1'b0;
      if (r_state == c_RUN) r_cpu_ready <= 1'b1;

      case (r_state)
        c_HOLD: begin
          if (r_hold_cnt == '0) begin
            r_state <= c_IDLE;
          end else begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
          end
        end
        default: begin
          if (w_pop) begin
            case (w_op)
              c_OP_WRITE: begin
                r_mem_addr  <= w_addr;
                r_mem_in    <= w_data;
                r_mem_write <= 1'b1;
                r_cpu_ready <= 1'b0;
              end
              c_OP_RESET: begin
                r_cpu_reset <= 1'b1;
                r_cpu_ready <= 1'b0;
                r_hold_cnt  <= c_HOLD_LOAD;
                r_state     <= c_HOLD;
              end
              c_OP_START: begin
                r_cpu_start_addr <= w_addr;
                r_cpu_reset      <= 1'b0;
                r_cpu_ready      <= 1'b1;
                r_state          <= c_RUN;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign bus.readdata       = r_readdata;
  assign bus.mem_addr       = r_mem_addr;
  assign bus.mem_in         = r_mem_in;
  assign bus.mem_write      = r_mem_write;
  assign bus.cpu_reset      = r_cpu_reset;
  assign bus.cpu_ready      = r_cpu_ready;
  assign bus.cpu_start_addr = r_cpu_start_addr;
  assign bus.busy           = ~w_empty | (r_state == c_HOLD);
endmodule
`default_nettype wire

// File: tb/tb_nes_host_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_nes_host_loader                                                 |
// | Directed plus random stimulus against a queue-based command model. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_nes_host_loader;
  localparam int DEPTH = 8;
  localparam int RCYC  = 4;

  logic clk = 1'b0;
  logic reset;

  nes_host_loader_if bus();

  nes_host_loader #(.FIFO_DEPTH(DEPTH), .RESET_CYCLES(RCYC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int pulses = 0;

  typedef struct packed {
    logic [7:0]  op;
    logic [7:0]  data;
    logic [15:0] addr;
  } cmd_t;

  cmd_t        q[$];
  bit          m_hold, m_run, m_ovf;
  longint      edge_n = 0;
  longint      hold_end = 0;
  logic [7:0]  m_rd, m_din;
  logic [15:0] m_addr, m_start;
  logic        m_mw, m_creset, m_rdy;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    q.delete();
    m_hold = 0; m_run = 0; m_ovf = 0;
    m_rd = 8'h00; m_din = 8'h00; m_addr = 16'h0; m_start = 16'h0;
    m_mw = 0; m_creset = 1; m_rdy = 0;
  endfunction

  // One clock edge of the command front end, from pre-edge inputs and state.
  function automatic void m_step();
    cmd_t c;
    bit   was_full, was_empty, popped;
    edge_n++;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (bus.chipselect && bus.read) begin
      m_rd  = {3'b000, m_hold, m_run, m_ovf, was_full, was_empty};
      m_ovf = 0;
    end
    if (bus.chipselect && bus.write && was_full) m_ovf = 1;
    m_mw   = 0;
    popped = 0;
    if (m_hold) begin
      if (edge_n == hold_end) m_hold = 0;
    end else if (!was_empty) begin
      c = q.pop_front();
      popped = 1;
      case (c.op)
        8'h02: begin m_addr = c.addr; m_din = c.data; m_mw = 1; m_rdy = 0; end
        8'h00: begin m_creset = 1; m_rdy = 0; m_run = 0; m_hold = 1; hold_end = edge_n + RCYC; end
        8'h01: begin m_start = c.addr; m_creset = 0; m_rdy = 1; m_run = 1; end
        default: if (m_run) m_rdy = 1;
      endcase
    end
    if (!popped && m_run) m_rdy = 1;
    if (bus.chipselect && bus.write && !was_full) q.push_back({bus.writedata, bus.address});
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m_reset();
    else       m_step();
  end

  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      chk("readdata",       {8'h00, bus.readdata}, {8'h00, m_rd});
      chk("mem_addr",       bus.mem_addr,          m_addr);
      chk("mem_in",         {8'h00, bus.mem_in},   {8'h00, m_din});
      chk("mem_write",      {15'h0, bus.mem_write}, {15'h0, m_mw});
      chk("cpu_reset",      {15'h0, bus.cpu_reset}, {15'h0, m_creset});
      chk("cpu_ready",      {15'h0, bus.cpu_ready}, {15'h0, m_rdy});
      chk("cpu_start_addr", bus.cpu_start_addr,    m_start);
      chk("busy",           {15'h0, bus.busy},     {15'h0, (q.size() != 0) || m_hold});
    end
  end

  always @(negedge clk) if (chk_en && bus.mem_write === 1'b1) pulses++;

  task automatic host_write(input logic [7:0] op, input logic [7:0] data, input logic [15:0] addr);
    bus.chipselect = 1; bus.write = 1; bus.writedata = {op, data}; bus.address = addr;
    @(negedge clk);
    bus.chipselect = 0; bus.write = 0;
  endtask

  task automatic host_read(output logic [7:0] val);
    bus.chipselect = 1; bus.read = 1;
    @(negedge clk);
    bus.chipselect = 0; bus.read = 0;
    #1 val = bus.readdata;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (bus.busy && n < max) begin @(negedge clk); n++; end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy %b after %0d cycles, required 0", bus.busy, max);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] st;
    int p0;
    bus.chipselect = 0; bus.write = 0; bus.read = 0; bus.writedata = 0; bus.address = 0;
    reset = 0;
    #2 reset = 1;
    m_reset();
    repeat (2) @(negedge clk);
    chk_en = 1;
    #2;
    chk("rst_cpu_reset", {15'h0, bus.cpu_reset}, 16'h1);
    chk("rst_busy",      {15'h0, bus.busy},      16'h0);
    chk("rst_readdata",  {8'h0, bus.readdata},   16'h0);
    @(negedge clk);
    reset = 0;

    // WRITE latency after reset
    host_write(8'h02, 8'h34, 16'h8000);
    @(negedge clk); #2;
    chk("t1_mem_write", {15'h0, bus.mem_write}, 16'h1);
    chk("t1_mem_addr",  bus.mem_addr,           16'h8000);
    chk("t1_mem_in",    {8'h0, bus.mem_in},     16'h0034);
    chk("t1_cpu_reset", {15'h0, bus.cpu_reset}, 16'h1);
    @(negedge clk); #2;
    chk("t1_pulse_end", {15'h0, bus.mem_write}, 16'h0);

    // RESET_CPU hold, then START_CPU
    wait_idle(20);
    host_write(8'h00, 8'h00, 16'h0000);
    host_write(8'h01, 8'h00, 16'hC000);
    repeat (4) @(negedge clk); #2;
    chk("t2_hold_reset", {15'h0, bus.cpu_reset}, 16'h1);
    chk("t2_hold_start", bus.cpu_start_addr,     16'h0000);
    @(negedge clk); #2;
    chk("t2_start_addr", bus.cpu_start_addr,     16'hC000);
    chk("t2_cpu_reset",  {15'h0, bus.cpu_reset}, 16'h0);
    chk("t2_cpu_ready",  {15'h0, bus.cpu_ready}, 16'h1);
    host_read(st);
    chk("t2_status", {8'h0, st}, 16'h0009);

    // Back-to-back WRITEs in RUN
    wait_idle(20);
    p0 = pulses;
    host_write(8'h02, 8'h11, 16'h0000);
    host_write(8'h02, 8'h22, 16'h0001);
    host_write(8'h02, 8'h33, 16'h0002);
    @(negedge clk); #2;
    chk("t3_last_addr", bus.mem_addr,           16'h0002);
    chk("t3_last_data", {8'h0, bus.mem_in},     16'h0033);
    chk("t3_ready_low", {15'h0, bus.cpu_ready}, 16'h0);
    @(negedge clk); #2;
    chk("t3_ready_back", {15'h0, bus.cpu_ready}, 16'h1);
    chk("t3_pulses", 16'(pulses - p0), 16'd3);

    // Overflow during RESET_CPU holds
    wait_idle(20);
    host_write(8'h00, 8'h00, 16'h0000);
    host_write(8'h00, 8'h00, 16'h0000);
    for (int i = 1; i <= 9; i++) host_write(8'h02, 8'(i), 16'h0100 + 16'(i));
    host_read(st);
    chk("t4_status1", {8'h0, st}, 16'h0006);
    host_read(st);
    chk("t4_ovf_clear", {15'h0, st[2]}, 16'h0);

    // Unknown opcode is ignored
    wait_idle(60);
    host_write(8'h7F, 8'h99, 16'h4444);
    host_write(8'h02, 8'h55, 16'h0010);
    #2;
    chk("t5_bad_op_mw",   {15'h0, bus.mem_write}, 16'h0);
    chk("t5_bad_op_addr", bus.mem_addr,           16'h0108);
    @(negedge clk); #2;
    chk("t5_mem_write", {15'h0, bus.mem_write}, 16'h1);
    chk("t5_mem_addr",  bus.mem_addr,           16'h0010);
    chk("t5_mem_in",    {8'h0, bus.mem_in},     16'h0055);

    // Reset while RUN with a backlog
    wait_idle(20);
    host_write(8'h00, 8'h00, 16'h0000);
    host_write(8'h01, 8'h00, 16'h1234);
    for (int i = 0; i < 5; i++) host_write(8'h02, 8'hA0 + 8'(i), 16'h2000 + 16'(i));
    repeat (2) @(negedge clk);
    chk("t6_pre_busy",  {15'h0, bus.busy}, 16'h1);
    chk("t6_pre_start", bus.cpu_start_addr, 16'h1234);
    reset = 1;
    #2;
    chk("t6_cpu_reset", {15'h0, bus.cpu_reset}, 16'h1);
    chk("t6_busy",      {15'h0, bus.busy},      16'h0);
    chk("t6_mem_write", {15'h0, bus.mem_write}, 16'h0);
    chk("t6_start",     bus.cpu_start_addr,     16'h0000);
    chk("t6_ready",     {15'h0, bus.cpu_ready}, 16'h0);
    p0 = pulses;
    @(negedge clk);
    reset = 0;
    repeat (10) @(negedge clk);
    chk("t6_no_pulses", 16'(pulses - p0), 16'd0);

    // Randomized traffic
    for (int n = 0; n < 700; n++) begin
      int r;
      logic [7:0] op;
      r = int'($urandom_range(0, 99));
      if (r < 70)      op = 8'h02;
      else if (r < 78) op = 8'h00;
      else if (r < 88) op = 8'h01;
      else             op = 8'($urandom_range(3, 255));
      bus.writedata  = {op, 8'($urandom)};
      bus.address    = 16'($urandom);
      bus.write      = ($urandom_range(0, 99) < 55);
      bus.read       = ($urandom_range(0, 99) < 20);
      bus.chipselect = ($urandom_range(0, 99) < 85);
      reset          = ($urandom_range(0, 249) == 0);
      @(negedge clk);
    end
    bus.chipselect = 0; bus.write = 0; bus.read = 0; reset = 0;
    wait_idle(100);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
